// File: rtl/seek_ctrl.sv
// Head-positioning sequencer: turns seek/home commands into timed step/dir pulses,
// tracks the current cylinder and recalibrates against the track-0 sensor.
module seek_ctrl #(
    parameter int DIR_SETUP_CYC   = 100,
    parameter int STEP_HIGH_CYC   = 50,
    parameter int STEP_PERIOD_CYC = 300000,
    parameter int SETTLE_CYC      = 1500000,
    parameter int MAX_TRACK       = 79,
    parameter int HOME_MAX_STEPS  = 90,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_home,
    input  logic [6:0] cmd_track,
    input  logic       tr0,
    output logic       step,
    output logic       dir,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [6:0] cur_track,
    output logic       track_valid
);

    localparam int HS_W = $clog2(HOME_MAX_STEPS + 1);

    // Counters load N-1 and run down to zero, so each timed state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(DIR_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HIGH   = CNT_W'(STEP_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LOW    = CNT_W'(STEP_PERIOD_CYC - STEP_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYC - 1);
    localparam logic [HS_W-1:0]  HS_MAX    = HS_W'(HOME_MAX_STEPS);
    localparam logic [6:0]       TRK_MAX   = 7'(MAX_TRACK);

    typedef enum logic [2:0] {
        IDLE,
        DIR_SETUP,
        STEP_HI,
        STEP_LO,
        SETTLE,
        REPORT
    } state_t;

    typedef enum logic [1:0] {
        DEC_STEP,
        DEC_SETTLE,
        DEC_HOMED,
        DEC_FAIL
    } dec_t;

    state_t           state;
    dec_t             dec;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       target;
    logic             homing;
    logic [HS_W-1:0]  home_steps;
    logic             tr0_meta;
    logic             tr0_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            tr0_meta <= 1'b0;
            tr0_sync <= 1'b0;
        end else begin
            tr0_meta <= tr0;
            tr0_sync <= tr0_meta;
        end
    end

    // What to do at the step decision point; the sensor wins over the step limit.
    always_comb begin
        dec = DEC_STEP;
        if (homing) begin
            if (tr0_sync)
                dec = DEC_HOMED;
            else if (home_steps == HS_MAX)
                dec = DEC_FAIL;
        end else if (cur_track == target) begin
            dec = DEC_SETTLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            target      <= '0;
            homing      <= 1'b0;
            home_steps  <= '0;
            step        <= 1'b0;
            dir         <= 1'b1;
            cur_track   <= '0;
            track_valid <= 1'b0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        if (cmd_home) begin
                            homing      <= 1'b1;
                            dir         <= 1'b1;
                            track_valid <= 1'b0;
                            home_steps  <= '0;
                            cnt         <= LD_SETUP;
                            state       <= DIR_SETUP;
                        end else if (!track_valid || cmd_track > TRK_MAX) begin
                            done  <= 1'b1;
                            error <= 1'b1;
                            state <= REPORT;
                        end else if (cmd_track == cur_track) begin
                            done  <= 1'b1;
                            state <= REPORT;
                        end else begin
                            homing <= 1'b0;
                            target <= cmd_track;
                            dir    <= (cmd_track < cur_track);
                            cnt    <= LD_SETUP;
                            state  <= DIR_SETUP;
                        end
                    end
                end

                DIR_SETUP, STEP_LO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        case (dec)
                            DEC_STEP: begin
                                step  <= 1'b1;
                                cnt   <= LD_HIGH;
                                state <= STEP_HI;
                                if (homing) begin
                                    home_steps <= home_steps + 1'b1;
                                    if (cur_track != '0)
                                        cur_track <= cur_track - 7'd1;
                                end else if (dir) begin
                                    cur_track <= cur_track - 7'd1;
                                end else begin
                                    cur_track <= cur_track + 7'd1;
                                end
                            end
                            DEC_SETTLE: begin
                                cnt   <= LD_SETTLE;
                                state <= SETTLE;
                            end
                            DEC_HOMED: begin
                                cur_track   <= '0;
                                track_valid <= 1'b1;
                                cnt         <= LD_SETTLE;
                                state       <= SETTLE;
                            end
                            default: begin
                                done  <= 1'b1;
                                error <= 1'b1;
                                state <= REPORT;
                            end
                        endcase
                    end
                end

                STEP_HI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        step  <= 1'b0;
                        cnt   <= LD_LOW;
                        state <= STEP_LO;
                    end
                end

                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        done  <= 1'b1;
                        state <= REPORT;
                    end
                end

                REPORT: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    step      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
